// File: rtl/avr_intc_pkg.sv
// Shared constants for the avr_intc interrupt controller: register selects,
// FSM state encoding and the STAT register layout.
package avr_intc_pkg;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_MODE = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int STAT_ACTIVE = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/avr_intc_prio.sv
// Combinational lowest-index-wins priority encoder for the interrupt sources.
module avr_intc_prio #(
  parameter int NSRC = 8,
  parameter int VW   = 3
) (
  input  logic [NSRC-1:0] req,
  output logic [VW-1:0]   vect,
  output logic            any
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    vect = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) vect = VW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/avr_intc.sv
// Maskable edge/level interrupt controller in front of the AVR core.
// Define AVR_INTC_SYNC_EN to put a 2-flop synchroniser on every irq_i bit.
module avr_intc
  import avr_intc_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int VW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_i,
  input  logic [1:0]      reg_sel,
  input  logic            reg_we,
  input  logic [7:0]      data_i,
  output logic [7:0]      data_o,
  output logic            intr,
  output logic [VW-1:0]   vect,
  input  logic            iack
);

  logic [NSRC-1:0] irq_s;
  logic [NSRC-1:0] irq_prev_reg;
  logic [NSRC-1:0] mask_reg;
  logic [NSRC-1:0] mode_reg;
  logic [NSRC-1:0] pend_reg;
  logic [NSRC-1:0] pend_next;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] vect_onehot;
  logic            vect_live;
  logic [VW-1:0]   win_vect;
  logic            win_any;
  logic            ack_take;
  state_t          state_reg;
  state_t          state_next;
  logic            intr_reg;
  logic            intr_next;
  logic [VW-1:0]   vect_reg;
  logic [VW-1:0]   vect_next;

`ifdef AVR_INTC_SYNC_EN
  logic [NSRC-1:0] sync1_reg;
  logic [NSRC-1:0] sync2_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq_i;
      sync2_reg <= sync1_reg;
    end
  end

  assign irq_s = sync2_reg;
`else
  assign irq_s = irq_i;
`endif

  assign active      = pend_reg & mask_reg;
  assign w1c         = (reg_we && reg_sel == REG_PEND) ? data_i[NSRC-1:0] : '0;
  assign vect_onehot = NSRC'(1) << vect_reg;
  assign vect_live   = |(active & vect_onehot);
  assign ack_clr     = ack_take ? vect_onehot : '0;

  // Edge sources: a fresh rising edge beats any clear in the same cycle.
  // Level sources simply follow the line and ignore clears.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_pend
      assign pend_next[gi] = mode_reg[gi]
          ? ((irq_s[gi] & ~irq_prev_reg[gi]) | (pend_reg[gi] & ~(w1c[gi] | ack_clr[gi])))
          : irq_s[gi];
    end
  endgenerate

  avr_intc_prio #(.NSRC(NSRC), .VW(VW)) u_prio (
    .req  (active),
    .vect (win_vect),
    .any  (win_any)
  );

  always_comb begin
    state_next = state_reg;
    intr_next  = intr_reg;
    vect_next  = vect_reg;
    ack_take   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_any) begin
          state_next = REQ;
          intr_next  = 1'b1;
          vect_next  = win_vect;
        end
      end
      REQ: begin
        // vect stays frozen here; a higher-priority arrival waits its turn.
        if (iack) begin
          ack_take   = 1'b1;
          intr_next  = 1'b0;
          state_next = HOLD;
        end else if (!vect_live) begin
          intr_next  = 1'b0;
          state_next = IDLE;
        end
      end
      HOLD: state_next = IDLE;
      default: begin
        state_next = IDLE;
        intr_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      intr_reg     <= 1'b0;
      vect_reg     <= '0;
      irq_prev_reg <= '0;
      mask_reg     <= '0;
      mode_reg     <= '0;
      pend_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      intr_reg     <= intr_next;
      vect_reg     <= vect_next;
      irq_prev_reg <= irq_s;
      pend_reg     <= pend_next;
      if (reg_we && reg_sel == REG_MASK) mask_reg <= data_i[NSRC-1:0];
      if (reg_we && reg_sel == REG_MODE) mode_reg <= data_i[NSRC-1:0];
    end
  end

  always_comb begin
    data_o = 8'h00;
    case (reg_sel)
      REG_MASK: data_o[NSRC-1:0] = mask_reg;
      REG_PEND: data_o[NSRC-1:0] = pend_reg;
      REG_MODE: data_o[NSRC-1:0] = mode_reg;
      default: begin
        data_o[STAT_ACTIVE] = intr_reg;
        data_o[VW-1:0]      = vect_reg;
      end
    endcase
  end

  assign intr = intr_reg;
  assign vect = vect_reg;

endmodule

// File: tb/tb_avr_intc.sv
// Self-checking bench for avr_intc: directed vector table, hand sequences for
// ack gap / level / reset, then random traffic against a cycle-level model.
module tb_avr_intc;

  logic       clock;
  logic       reset_n;
  logic [7:0] irq_i;
  logic [1:0] reg_sel;
  logic       reg_we;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       intr;
  logic [2:0] vect;
  logic       iack;

  int checks   = 0;
  int failures = 0;

  avr_intc #(.NSRC(8), .VW(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .irq_i   (irq_i),
    .reg_sel (reg_sel),
    .reg_we  (reg_we),
    .data_i  (data_i),
    .data_o  (data_o),
    .intr    (intr),
    .vect    (vect),
    .iack    (iack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
`ifdef AVR_INTC_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif
  logic [7:0] m_mask, m_mode, m_pend, m_prev;
  logic       m_intr;
  int         m_vect;
  int         m_cyc, m_allow;
  logic [7:0] m_dly [2];

  task automatic model_reset();
    m_mask = 0; m_mode = 0; m_pend = 0; m_prev = 0;
    m_intr = 0; m_vect = 0; m_cyc = 0; m_allow = 0;
    m_dly[0] = 0; m_dly[1] = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] s);
    case (s)
      2'd0: return m_mask;
      2'd1: return m_pend;
      2'd2: return m_mode;
      default: return {m_intr, 4'b0000, 3'(m_vect)};
    endcase
  endfunction

  // One rising edge worth of behaviour, using the values held before the edge.
  task automatic model_step(input logic [7:0] q, input logic [1:0] s, input logic w,
                            input logic [7:0] d, input logic a);
    logic [7:0] irq_e, active, clr, nxt;
    int win;
    irq_e = (SYNC_DLY == 2) ? m_dly[1] : q;
    m_dly[1] = m_dly[0];
    m_dly[0] = q;
    active = m_pend & m_mask;
    clr = (w && s == 2'd1) ? d : 8'h00;
    if (m_intr) begin
      if (a) begin
        clr[m_vect] = 1'b1;
        m_intr  = 0;
        m_allow = m_cyc + 2;
      end else if (!active[m_vect]) begin
        m_intr = 0;
      end
    end else if (m_cyc >= m_allow && active != 0) begin
      win = 0;
      for (int i = 7; i >= 0; i--) if (active[i]) win = i;
      m_intr = 1;
      m_vect = win;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_mode[i]) nxt[i] = (irq_e[i] && !m_prev[i]) || (m_pend[i] && !clr[i]);
      else           nxt[i] = irq_e[i];
    end
    m_pend = nxt;
    if (w && s == 2'd0) m_mask = d;
    if (w && s == 2'd2) m_mode = d;
    m_prev = irq_e;
    m_cyc++;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, return at the next falling edge.
  task automatic cyc(input logic [1:0] s, input logic w, input logic [7:0] d,
                     input logic [7:0] q, input logic a);
    reg_sel = s; reg_we = w; data_i = d; irq_i = q; iack = a;
    model_step(q, s, w, d, a);
    @(posedge clock);
    @(negedge clock);
    reg_we = 1'b0;
    iack   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    irq_i = 0; reg_sel = 0; reg_we = 0; data_i = 0; iack = 0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic [1:0] sel;
    logic       we;
    logic [7:0] din;
    logic [7:0] irq;
    logic       ack;
    logic       e_intr;
    logic [2:0] e_vect;
    logic [7:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] s, input logic w, input logic [7:0] d,
                              input logic [7:0] q, input logic a, input logic ei,
                              input logic [2:0] ev, input logic [7:0] ed);
    vec_t v;
    v.sel = s; v.we = w; v.din = d; v.irq = q; v.ack = a;
    v.e_intr = ei; v.e_vect = ev; v.e_data = ed;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [7:0] rq;
    logic [1:0] rs;
    logic       rw, ra;
    logic [7:0] rd;

    // Reset readback, single edge source, two-edge priority, set-beats-W1C.
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(2, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(3, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 8'h10, 8'h00, 0, 0, 0, 8'h10));
    tbl.push_back(mk(2, 1, 8'h10, 8'h00, 0, 0, 0, 8'h10));
    tbl.push_back(mk(1, 0, 8'h00, 8'h10, 0, 0, 0, 8'h10));
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 1, 4, 8'h10));
    tbl.push_back(mk(3, 0, 8'h00, 8'h00, 1, 0, 4, 8'h04));
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 4, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 4, 8'h00));
    tbl.push_back(mk(0, 1, 8'hFF, 8'h00, 0, 0, 4, 8'hFF));
    tbl.push_back(mk(2, 1, 8'hFF, 8'h00, 0, 0, 4, 8'hFF));
    tbl.push_back(mk(1, 0, 8'h00, 8'h44, 0, 0, 4, 8'h44));
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 1, 2, 8'h44));
    tbl.push_back(mk(3, 0, 8'h00, 8'h00, 1, 0, 2, 8'h02));
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 2, 8'h40));
    tbl.push_back(mk(3, 0, 8'h00, 8'h00, 0, 1, 6, 8'h86));
    tbl.push_back(mk(3, 0, 8'h00, 8'h00, 1, 0, 6, 8'h06));
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 6, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 6, 8'h00));
    tbl.push_back(mk(1, 1, 8'h08, 8'h08, 0, 0, 6, 8'h08));
    tbl.push_back(mk(1, 0, 8'h00, 8'h08, 0, 1, 3, 8'h08));
    tbl.push_back(mk(1, 1, 8'h08, 8'h00, 0, 1, 3, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 3, 8'h00));

    do_reset();
    @(negedge clock);
    chk("reset_intr", {7'b0, intr}, 8'h00);
    chk("reset_vect", {5'b0, vect}, 8'h00);

`ifndef AVR_INTC_SYNC_EN
    foreach (tbl[i]) begin
      cyc(tbl[i].sel, tbl[i].we, tbl[i].din, tbl[i].irq, tbl[i].ack);
      $display("row %0d sel=%0d we=%0b irq=0x%02h ack=%0b -> intr=%0b vect=%0d data=0x%02h",
               i, tbl[i].sel, tbl[i].we, tbl[i].irq, tbl[i].ack, intr, vect, data_o);
      chk($sformatf("row%0d_intr", i), {7'b0, intr}, {7'b0, tbl[i].e_intr});
      chk($sformatf("row%0d_vect", i), {5'b0, vect}, {5'b0, tbl[i].e_vect});
      chk($sformatf("row%0d_data", i), data_o, tbl[i].e_data);
    end

    // Level source: ack gap of HOLD + IDLE, re-request, then release while in REQ.
    cyc(0, 1, 8'h01, 8'h00, 0);
    cyc(2, 1, 8'h00, 8'h00, 0);
    cyc(1, 0, 8'h00, 8'h01, 0);
    chk("lvl_pend", data_o, 8'h01);
    chk("lvl_pre_intr", {7'b0, intr}, 8'h00);
    cyc(1, 0, 8'h00, 8'h01, 0);
    chk("lvl_intr", {7'b0, intr}, 8'h01);
    chk("lvl_vect", {5'b0, vect}, 8'h00);
    cyc(1, 0, 8'h00, 8'h01, 1);
    chk("lvl_ack_drop", {7'b0, intr}, 8'h00);
    cyc(1, 0, 8'h00, 8'h01, 0);
    chk("lvl_gap", {7'b0, intr}, 8'h00);
    cyc(1, 0, 8'h00, 8'h01, 0);
    chk("lvl_rereq", {7'b0, intr}, 8'h01);
    chk("lvl_rereq_vect", {5'b0, vect}, 8'h00);
    $display("level sequence intr=%0b vect=%0d", intr, vect);
    cyc(1, 0, 8'h00, 8'h00, 0);
    cyc(1, 0, 8'h00, 8'h00, 0);
    chk("lvl_release", {7'b0, intr}, 8'h00);

    // Asynchronous reset in the middle of a request.
    cyc(1, 0, 8'h00, 8'h01, 0);
    cyc(1, 0, 8'h00, 8'h01, 0);
    chk("rst_pre_intr", {7'b0, intr}, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_intr", {7'b0, intr}, 8'h00);
    reg_sel = 2'd1;
    #1 chk("rst_pend", data_o, 8'h00);
    reg_sel = 2'd0;
    #1 chk("rst_mask", data_o, 8'h00);
    $display("async reset mid-request intr=%0b", intr);
    do_reset();
    @(negedge clock);
`else
    // With the synchroniser the edge reaches PEND two cycles later.
    cyc(0, 1, 8'h10, 8'h00, 0);
    cyc(2, 1, 8'h10, 8'h00, 0);
    cyc(1, 0, 8'h00, 8'h10, 0);
    chk("sync_k0", {7'b0, intr}, 8'h00);
    cyc(1, 0, 8'h00, 8'h00, 0);
    chk("sync_k1", {7'b0, intr}, 8'h00);
    cyc(1, 0, 8'h00, 8'h00, 0);
    chk("sync_k2", {7'b0, intr}, 8'h00);
    chk("sync_pend", data_o, 8'h10);
    cyc(1, 0, 8'h00, 8'h00, 0);
    chk("sync_k3_intr", {7'b0, intr}, 8'h01);
    chk("sync_k3_vect", {5'b0, vect}, 8'h04);
    $display("sync edge sequence intr=%0b vect=%0d", intr, vect);
    do_reset();
    @(negedge clock);
`endif

    // Random traffic against the model.
    rq = 0;
    for (int n = 0; n < 1500; n++) begin
      rq = rq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      rs = 2'($urandom);
      rw = ($urandom_range(0, 5) == 0);
      rd = 8'($urandom);
      if (rw && rs == 2'd0) rd = rd | 8'($urandom);
      ra = ($urandom_range(0, 2) == 0);
      if (ra && m_intr) $display("rand ack cycle=%0d vect=%0d", n, m_vect);
      cyc(rs, rw, rd, rq, ra);
      chk("rand_intr", {7'b0, intr}, {7'b0, m_intr});
      chk("rand_vect", {5'b0, vect}, 8'(m_vect));
      chk("rand_data", data_o, model_read(rs));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
